source: RTL and testbench
=========================

SOURCE -- requirements
Module: source

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as stated below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 instruction  input  16  instruction word: opcode [15:12], field A [11:8], field B [7:4], field D [3:0].
REQ-005 memory  output  128  flat view of the 16x8-bit register file; byte k SHALL appear on bits [8k+7:8k].
REQ-006 r1  output  8  registered first operand, mem[A].
REQ-007 r2  output  8  registered second operand, mem[B].
REQ-008 r3  output  8  registered result of the executed instruction.

Function
REQ-009 One instruction SHALL execute per rising clk edge, with single-cycle latency and no handshake; instruction SHALL be sampled at each edge.
REQ-010 At each edge, the block SHALL compute a = mem[A], b = mem[B] and res from pre-edge memory, then update r1 <= a, r2 <= b and r3 <= res, and write mem[D] <= res unless the opcode is NOP.
REQ-011 When D equals A or B, the read SHALL return the old value and the write SHALL take effect after the edge.
REQ-012 All arithmetic SHALL be 8-bit modulo 256; carries and borrows SHALL be discarded.
REQ-013 Opcode table:
- 0 ADD: res = a+b
- 1 SUB: res = a-b
- 2 AND: res = a&b
- 3 OR: res = a|b
- 4 XOR: res = a^b
- 5 NOT: res = ~a
- 6 SHL: res = a << b[2:0]
- 7 SHR: logical, res = a >> b[2:0]
- 8 ROL: res = a rotated left by b[2:0]
- 9 ROR: res = a rotated right by b[2:0]
- A MOV: res = a
- B INC: res = a+1
- C DEC: res = a-1
- D LDI: res = {A,B}, the 8-bit immediate instruction[11:4]
- E SLT: res = (a<b, unsigned) ? 1 : 0
- F NOP: res = 0, no memory write
REQ-014 The memory output SHALL always reflect the current register-file contents, with no extra latency.

Reset
REQ-015 While rst_n is low, memory byte k SHALL be k for k = 0..15, and r1, r2 and r3 SHALL be 0x00.
REQ-016 Reset SHALL take effect immediately, independent of clk, including mid-sequence.
REQ-017 The first instruction SHALL execute on the first rising edge after rst_n goes high.

Structure
REQ-018 Opcode constants and widths (data 8, address 4, depth 16) SHALL reside in the shared package source_pkg.
REQ-019 Combinational result computation SHALL be a sub-module source_alu (inputs op, a, b, imm; output res); the register file and output registers SHALL remain in source.

Verification
REQ-020 After reset, apply 0x0020, then 0x0031, then 0xD012 on three consecutive edges:
- after edge 1: r1=0x00, r2=0x02, r3=0x02, mem0=0x02
- after edge 2: r1=0x02, r2=0x03, r3=0x05, mem1=0x05
- after edge 3: r1=0x02, r2=0x05, r3=0x01, mem2=0x01
REQ-021 After reset, apply 0x1120 -> mem0=0xFF and r3=0xFF (subtraction wrap-around).
REQ-022 After reset, apply 0x6F3E (SHL A=15, B=3, D=14) -> mem14=0x78; then apply 0x8E1D (ROL A=14, B=1, D=13) -> mem13=0xF0.
REQ-023 After reset, apply 0xF123 -> memory unchanged and r3=0x00; then apply 0xE231 -> mem1=0x01 (2<3).
REQ-024 Assert rst_n low asynchronously between edges after several writes -> memory returns immediately to bytes 0..15 and r1, r2, r3 return to 0x00 without waiting for a clk edge.

Source files
------------

// File: rtl/source_pkg.sv
// Shared widths and opcode encodings for the source register-file processor.
// The ALU and the register-file top both import this package.
package source_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_NOT = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_ROL = 4'h8,
        OP_ROR = 4'h9,
        OP_MOV = 4'hA,
        OP_INC = 4'hB,
        OP_DEC = 4'hC,
        OP_LDI = 4'hD,
        OP_SLT = 4'hE,
        OP_NOP = 4'hF
    } opcode_e;

endpackage

// File: rtl/source_alu.sv
// Combinational 8-bit result unit for one instruction.
// All arithmetic wraps modulo 256; shift and rotate amounts use b[2:0].
module source_alu
    import source_pkg::*;
(
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] res
);

    logic [2:0]            sh;
    logic [2*DATA_W-1:0]   rol_wide;
    logic [2*DATA_W-1:0]   ror_wide;

    // Rotates come from shifting a doubled copy of a and keeping one byte.
    assign sh       = b[2:0];
    assign rol_wide = {a, a} << sh;
    assign ror_wide = {a, a} >> sh;

    always_comb begin
        res = '0;
        case (op)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: res = a << sh;
            OP_SHR: res = a >> sh;
            OP_ROL: res = rol_wide[2*DATA_W-1:DATA_W];
            OP_ROR: res = ror_wide[DATA_W-1:0];
            OP_MOV: res = a;
            OP_INC: res = a + 8'd1;
            OP_DEC: res = a - 8'd1;
            OP_LDI: res = imm;
            OP_SLT: res = {7'd0, (a < b)};
            OP_NOP: res = '0;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/source.sv
// 16x8 register file executing one instruction per clock edge.
// Operands read pre-edge contents; the result lands in mem[D] after the edge.
module source
    import source_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             instruction,
    output logic [DEPTH*DATA_W-1:0] memory,
    output logic [DATA_W-1:0]       r1,
    output logic [DATA_W-1:0]       r2,
    output logic [DATA_W-1:0]       r3
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] r1_reg;
    logic [DATA_W-1:0] r2_reg;
    logic [DATA_W-1:0] r3_reg;

    opcode_e           op;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] res_next;

    assign op     = opcode_e'(instruction[15:12]);
    assign addr_a = instruction[11:8];
    assign addr_b = instruction[7:4];
    assign addr_d = instruction[3:0];
    assign opnd_a = mem_reg[addr_a];
    assign opnd_b = mem_reg[addr_b];

    source_alu u_alu (
        .op  (op),
        .a   (opnd_a),
        .b   (opnd_b),
        .imm (instruction[11:4]),
        .res (res_next)
    );

    // Reset loads each byte with its own index so the file is self-describing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_reg[k] <= DATA_W'(k);
            end
            r1_reg <= '0;
            r2_reg <= '0;
            r3_reg <= '0;
        end else begin
            r1_reg <= opnd_a;
            r2_reg <= opnd_b;
            r3_reg <= res_next;
            if (op != OP_NOP) begin
                mem_reg[addr_d] <= res_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem_flat
            assign memory[DATA_W*gi +: DATA_W] = mem_reg[gi];
        end
    endgenerate

    assign r1 = r1_reg;
    assign r2 = r2_reg;
    assign r3 = r3_reg;

endmodule

// File: tb/tb_source.sv
// Directed self-checking bench for the source register-file processor.
// Expected values are hand-computed from the opcode table.
`timescale 1ns/1ps
module tb_source;

    logic         clk;
    logic         rst_n;
    logic [15:0]  instruction;
    logic [127:0] memory;
    logic [7:0]   r1;
    logic [7:0]   r2;
    logic [7:0]   r3;

    int checks = 0;
    int errors = 0;

    source dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .memory      (memory),
        .r1          (r1),
        .r2          (r2),
        .r3          (r3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] reset_image();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(k);
        return v;
    endfunction

    function automatic logic [7:0] mem_byte(input int k);
        return memory[8*k +: 8];
    endfunction

    // Reset pulse placed between edges; leaves a NOP on the bus.
    task automatic do_reset();
        @(negedge clk);
        instruction = 16'hF000;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apply(input logic [15:0] instr);
        instruction = instr;
        @(posedge clk);
        #1;
        $display("instr=%h r1=%h r2=%h r3=%h", instr, r1, r2, r3);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instruction = 16'hF000;
        #1;
        checks++;
        if (memory !== reset_image()) begin
            errors++;
            $display("FAIL reset_mem: got %h required %h", memory, reset_image());
        end
        checks++;
        if ({r1, r2, r3} !== 24'h0) begin
            errors++;
            $display("FAIL reset_regs: got r1=%h r2=%h r3=%h required 00 00 00", r1, r2, r3);
        end
        // Reset must hold across a clock edge too.
        @(posedge clk);
        #1;
        checks++;
        if (memory !== reset_image() || {r1, r2, r3} !== 24'h0) begin
            errors++;
            $display("FAIL reset_hold: got mem=%h r=%h%h%h required reset image", memory, r1, r2, r3);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        apply(16'h0020);
        checks++;
        if ({r1, r2, r3, mem_byte(0)} !== 32'h00020202) begin
            errors++;
            $display("FAIL add_edge1: got %h %h %h mem0=%h required 00 02 02 mem0=02", r1, r2, r3, mem_byte(0));
        end
        apply(16'h0031);
        checks++;
        if ({r1, r2, r3, mem_byte(1)} !== 32'h02030505) begin
            errors++;
            $display("FAIL add_edge2: got %h %h %h mem1=%h required 02 03 05 mem1=05", r1, r2, r3, mem_byte(1));
        end
        apply(16'hD012);
        checks++;
        if ({r1, r2, r3, mem_byte(2)} !== 32'h02050101) begin
            errors++;
            $display("FAIL ldi_edge3: got %h %h %h mem2=%h required 02 05 01 mem2=01", r1, r2, r3, mem_byte(2));
        end
    endtask

    task automatic test_sub_wrap();
        do_reset();
        apply(16'h1120);
        checks++;
        if (mem_byte(0) !== 8'hFF || r3 !== 8'hFF) begin
            errors++;
            $display("FAIL sub_wrap: got mem0=%h r3=%h required FF FF", mem_byte(0), r3);
        end
    endtask

    task automatic test_shift_rotate();
        do_reset();
        apply(16'h6F3E);
        checks++;
        if (mem_byte(14) !== 8'h78) begin
            errors++;
            $display("FAIL shl: got mem14=%h required 78", mem_byte(14));
        end
        apply(16'h8E1D);
        checks++;
        if (mem_byte(13) !== 8'hF0) begin
            errors++;
            $display("FAIL rol: got mem13=%h required F0", mem_byte(13));
        end
        // Shift amount uses only b[2:0]: b=9 shifts by 1.
        apply(16'h6190);
        checks++;
        if (mem_byte(0) !== 8'h02) begin
            errors++;
            $display("FAIL shl_mod8: got mem0=%h required 02", mem_byte(0));
        end
        apply(16'h7F2E);
        checks++;
        if (mem_byte(14) !== 8'h03) begin
            errors++;
            $display("FAIL shr: got mem14=%h required 03", mem_byte(14));
        end
        apply(16'h9F1D);
        checks++;
        if (mem_byte(13) !== 8'h87) begin
            errors++;
            $display("FAIL ror: got mem13=%h required 87", mem_byte(13));
        end
    endtask

    task automatic test_nop_slt();
        do_reset();
        apply(16'hF123);
        checks++;
        if (memory !== reset_image() || r3 !== 8'h00) begin
            errors++;
            $display("FAIL nop: got mem=%h r3=%h required reset image r3=00", memory, r3);
        end
        apply(16'hE231);
        checks++;
        if (mem_byte(1) !== 8'h01 || r3 !== 8'h01) begin
            errors++;
            $display("FAIL slt_true: got mem1=%h r3=%h required 01 01", mem_byte(1), r3);
        end
        apply(16'hE324);
        checks++;
        if (mem_byte(4) !== 8'h00) begin
            errors++;
            $display("FAIL slt_false: got mem4=%h required 00", mem_byte(4));
        end
    endtask

    task automatic test_logic_ops();
        do_reset();
        apply(16'h2563);
        checks++;
        if (mem_byte(3) !== 8'h04) begin
            errors++;
            $display("FAIL and: got mem3=%h required 04", mem_byte(3));
        end
        apply(16'h3568);
        checks++;
        if (mem_byte(8) !== 8'h07) begin
            errors++;
            $display("FAIL or: got mem8=%h required 07", mem_byte(8));
        end
        apply(16'h4569);
        checks++;
        if (mem_byte(9) !== 8'h03) begin
            errors++;
            $display("FAIL xor: got mem9=%h required 03", mem_byte(9));
        end
        // D equals A: operand register sees the old value, write lands after.
        apply(16'h5A0A);
        checks++;
        if (r1 !== 8'h0A || mem_byte(10) !== 8'hF5) begin
            errors++;
            $display("FAIL not_self: got r1=%h mem10=%h required 0A F5", r1, mem_byte(10));
        end
        apply(16'hBA0B);
        checks++;
        if (mem_byte(11) !== 8'hF6) begin
            errors++;
            $display("FAIL inc: got mem11=%h required F6", mem_byte(11));
        end
        apply(16'hC00C);
        checks++;
        if (mem_byte(12) !== 8'hFF) begin
            errors++;
            $display("FAIL dec_wrap: got mem12=%h required FF", mem_byte(12));
        end
        apply(16'hA70F);
        checks++;
        if (mem_byte(15) !== 8'h07) begin
            errors++;
            $display("FAIL mov: got mem15=%h required 07", mem_byte(15));
        end
        apply(16'hDFF5);
        checks++;
        if (mem_byte(5) !== 8'hFF) begin
            errors++;
            $display("FAIL ldi_ff: got mem5=%h required FF", mem_byte(5));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(16'hD550);
        apply(16'hD661);
        apply(16'h0012);
        checks++;
        if (mem_byte(2) !== 8'hBB) begin
            errors++;
            $display("FAIL pre_reset_write: got mem2=%h required BB", mem_byte(2));
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (memory !== reset_image()) begin
            errors++;
            $display("FAIL async_reset_mem: got %h required %h", memory, reset_image());
        end
        checks++;
        if ({r1, r2, r3} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset_regs: got r1=%h r2=%h r3=%h required 00 00 00", r1, r2, r3);
        end
        instruction = 16'hF000;
        #1;
        rst_n = 1'b1;
        // First edge after release executes the pending instruction.
        apply(16'hD7E0);
        checks++;
        if (mem_byte(0) !== 8'h7E || mem_byte(1) !== 8'h01) begin
            errors++;
            $display("FAIL post_reset_first: got mem0=%h mem1=%h required 7E 01", mem_byte(0), mem_byte(1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instruction = 16'hF000;
        test_reset();
        test_back_to_back();
        test_sub_wrap();
        test_shift_rotate();
        test_nop_slt();
        test_logic_ops();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
